// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchroniser, 3-sample majority vote per bit,
// 8 data bits LSB first, optional parity, 1-cycle rdsig strobe per frame.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] OFS_A    = CW'(M - 1);
    localparam logic [CW-1:0] OFS_B    = CW'(M);
    localparam logic [CW-1:0] OFS_C    = CW'(M + 1);
    localparam logic [CW-1:0] OFS_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return (^d) ^ p ^ PARITY_ODD;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  smp_q, smp_d;
    logic [7:0]  shift_q, shift_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  dataout_q;
    logic        rdsig_q;
    logic        perr_out_q;
    logic        ferr_out_q;

    logic rx_s;
    logic decide;
    logic bit_v;

    assign rx_s   = sync_q[1];
    assign decide = (cnt_q == OFS_C);
    assign bit_v  = maj3(smp_q[0], smp_q[1], rx_s);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == OFS_LAST) ? '0 : cnt_q + 1'b1;
        bitcnt_d = bitcnt_q;
        pend_d   = 1'b0;
        smp_d    = smp_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;

        if (cnt_q == OFS_A) smp_d[0] = rx_s;
        if (cnt_q == OFS_B) smp_d[1] = rx_s;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d  = S_START;
                    cnt_d    = CW'(1);
                    bitcnt_d = '0;
                    perr_d   = 1'b0;
                end
            end
            S_START: begin
                if (decide) state_d = bit_v ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (decide) begin
                    shift_d  = {bit_v, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_d  = parity_bad(shift_q, bit_v);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    // Leave the stop bit early so a start edge right after it is caught.
                    pend_d  = 1'b1;
                    ferr_d  = ~bit_v;
                    state_d = bit_v ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            pend_q     <= 1'b0;
            rdsig_q    <= 1'b0;
            dataout_q  <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rx};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            pend_q   <= pend_d;
            rdsig_q  <= pend_q;
            if (pend_q) begin
                dataout_q  <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_q;
            end
        end
    end

    // Sample/shift storage is only consumed after a full frame, so it carries no reset.
    always_ff @(posedge clk) begin
        smp_q   <= smp_d;
        shift_q <= shift_d;
        perr_q  <= perr_d;
        ferr_q  <= ferr_d;
    end

    assign dataout    = dataout_q;
    assign rdsig      = rdsig_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign busy       = (state_q != S_IDLE);

endmodule
